// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and drives the imem fetch, then presents the
// fetched instruction for one execute slot before resolving the next PC.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        Resetb,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    input  logic [63:0] SignExtImm64,
    input  logic        core_stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic [63:0] CurrentPC,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]  r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic [31:0] r_tmo;
    logic        r_req;
    logic        r_valid;
    logic        r_halted;
    logic        r_fault;
    logic        w_taken;
    logic        w_tmo_done;
    logic [63:0] w_next_pc;

    assign w_taken    = (Branch & ALUZero) | Uncondbranch;
    assign w_next_pc  = r_pc + (w_taken ? SignExtImm64 << 2 : 64'd4);
    // r_tmo counts FETCH cycles already spent without an ack
    assign w_tmo_done = r_tmo == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_count  <= 32'd0;
            r_tmo    <= 32'd0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_tmo   <= 32'd0;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (w_tmo_done) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_EXEC: begin
                    if (!core_stall) begin
                        r_count <= r_count + 32'd1;
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        if (halt_req) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_req   <= 1'b1;
                            r_tmo   <= 32'd0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        r_halted <= 1'b0;
                        r_req    <= 1'b1;
                        r_tmo    <= 32'd0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FAULT: ;
                default: begin
                    r_req    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                    r_fault  <= 1'b1;
                    r_state  <= S_FAULT;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign CurrentPC   = r_pc;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign instr_count = r_count;
endmodule
